acc_apb_frontend: RTL and testbench

Parametrised APB slave front-end for the matrix accelerator, the successor to the single-channel accelerator top. It supports NUM_CH operand channels and buffers results in a FIFO. It sequences load, run and done through an explicit FSM and drives the clock-gate enable and start pulse. APB wait states are used for operand back-pressure, and PSLVERR flags protocol misuse. It sits between the APB interconnect and the accelerator datapath/controller.

---
 rtl/acc_pkg.sv | 35 +++
 rtl/acc_apb_frontend_if.sv | 18 +
 rtl/acc_res_fifo.sv | 53 +++++
 rtl/acc_apb_frontend.sv | 191 +++++++++++++++++++
 tb/tb_acc_apb_frontend.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_pkg.sv
// Shared definitions for the matrix accelerator APB front-end: address map,
// CTRL command codes, FSM state encoding and the STATUS register layout.
package acc_pkg;

  localparam int unsigned ADDR_CTRL    = 32'h000;
  localparam int unsigned ADDR_STATUS  = 32'h004;
  localparam int unsigned ADDR_IRQCLR  = 32'h008;
  localparam int unsigned ADDR_RESULT  = 32'h800;
  // Operand channel ch owns the 256 B window starting at 0x100*(ch+1).
  localparam int unsigned OP_WIN_SHIFT = 8;

  localparam int unsigned CTRL_START = 1;
  localparam int unsigned CTRL_ABORT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] rsvd_hi;
    logic [7:0] full_mask;
    logic [7:0] res_count;
    logic [4:0] rsvd_lo;
    logic       done;
    logic [1:0] state;
  } status_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_apb_frontend_if.sv
// APB3 completer-side bundle for the accelerator front-end.
interface acc_apb_frontend_if #(
  parameter int unsigned ADDR_W = 12
);
  logic [ADDR_W-1:0] PADDR;
  logic [31:0]       PWDATA;
  logic              PWRITE;
  logic              PSEL;
  logic              PENABLE;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/acc_res_fifo.sv
// Synchronous result FIFO with occupancy count and single-cycle flush.
module acc_res_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_apb_frontend.sv
// APB front-end for the matrix accelerator: operand loading with back-pressure,
// load/run/done sequencing, clock-gate and start control, result FIFO readout.
module acc_apb_frontend
  import acc_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 12,
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned WORDS_PER_CH   = 16,
  parameter int unsigned RES_DEPTH      = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  acc_apb_frontend_if.slave         apb,
  output logic                      clk_en_o,
  output logic                      start_o,
  input  logic                      done_i,
  output logic                      ld_valid_o,
  output logic [idx_w(NUM_CH)-1:0]  ld_ch_o,
  output logic [31:0]               ld_data_o,
  input  logic                      ld_ready_i,
  input  logic                      res_valid_i,
  input  logic [31:0]               res_data_i,
  output logic                      res_ready_o,
  output logic                      irq_o
);
  localparam int unsigned CH_W  = idx_w(NUM_CH);
  localparam int unsigned WIN_W = APB_ADDR_WIDTH - OP_WIN_SHIFT;
  localparam int unsigned CNT_W = $clog2(WORDS_PER_CH + 1);
  localparam int unsigned RC_W  = $clog2(RES_DEPTH) + 1;

  state_e              state_q, state_d;
  logic                clk_en_q, clk_en_d;
  logic                start_q, start_d;
  logic                settle_q, settle_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    cnt_q [NUM_CH];
  logic [CNT_W-1:0]    cnt_d [NUM_CH];
  logic [NUM_CH-1:0]   full_mask;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [WIN_W-1:0]    win;
  logic [CH_W-1:0]     ch;
  logic                access, wr;
  logic                hit_ctrl, hit_status, hit_irqclr, hit_res, hit_op;
  logic                cmd_start, cmd_abort, start_ok, op_ok, legal;
  logic                do_start, do_abort, do_irqclr, do_pop, ld_hs;
  logic [31:0]         prdata;
  status_t             status;

  logic [31:0]         res_head;
  logic [RC_W-1:0]     res_count;
  logic                res_full, res_empty;

  // Address decode; HRESETn gating drops any transfer caught by reset.
  assign paddr      = apb.PADDR;
  assign win        = paddr[APB_ADDR_WIDTH-1:OP_WIN_SHIFT];
  assign ch         = CH_W'(win - WIN_W'(1));
  assign access     = apb.PSEL && apb.PENABLE && HRESETn;
  assign wr         = apb.PWRITE;
  assign hit_ctrl   = (paddr == APB_ADDR_WIDTH'(ADDR_CTRL));
  assign hit_status = (paddr == APB_ADDR_WIDTH'(ADDR_STATUS));
  assign hit_irqclr = (paddr == APB_ADDR_WIDTH'(ADDR_IRQCLR));
  assign hit_res    = (paddr == APB_ADDR_WIDTH'(ADDR_RESULT));
  assign hit_op     = (win >= WIN_W'(1)) && (win <= WIN_W'(NUM_CH));

  always_comb begin
    for (int i = 0; i < int'(NUM_CH); i++) full_mask[i] = (cnt_q[i] == CNT_W'(WORDS_PER_CH));
  end

  assign cmd_start = hit_ctrl && wr && (apb.PWDATA == 32'(CTRL_START));
  assign cmd_abort = hit_ctrl && wr && (apb.PWDATA == 32'(CTRL_ABORT));
  assign start_ok  = cmd_start && (state_q == ST_LOAD) && (&full_mask);
  assign op_ok     = hit_op && wr && ((state_q == ST_IDLE) || (state_q == ST_LOAD)) && !full_mask[ch];
  assign legal     = cmd_abort || start_ok || (hit_status && !wr) || (hit_irqclr && wr)
                     || op_ok || (hit_res && !wr && !res_empty);

  assign ld_valid_o  = access && op_ok;
  assign ld_ch_o     = ld_valid_o ? ch : '0;
  assign ld_data_o   = ld_valid_o ? apb.PWDATA : '0;
  assign ld_hs       = ld_valid_o && ld_ready_i;
  assign apb.PREADY  = access && (op_ok ? ld_ready_i : 1'b1);
  assign apb.PSLVERR = access && !legal;

  assign do_start  = apb.PREADY && start_ok;
  assign do_abort  = apb.PREADY && cmd_abort;
  assign do_irqclr = apb.PREADY && hit_irqclr && wr;
  assign do_pop    = apb.PREADY && hit_res && !wr && !res_empty;

  always_comb begin
    status           = '0;
    status.state     = state_q;
    status.done      = done_q;
    status.res_count = 8'(res_count);
    status.full_mask = 8'(full_mask);
  end

  always_comb begin
    prdata = '0;
    if (access && !wr && legal) begin
      if (hit_status)   prdata = status;
      else if (hit_res) prdata = res_head;
    end
  end
  assign apb.PRDATA = prdata;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      clk_en_q <= 1'b0;
      start_q  <= 1'b0;
      settle_q <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      clk_en_q <= clk_en_d;
      start_q  <= start_d;
      settle_q <= settle_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
    end
  end

  // Start raises the gate first; the start pulse follows one settle cycle later.
  always_comb begin
    state_d  = state_q;
    clk_en_d = clk_en_q;
    start_d  = 1'b0;
    settle_d = 1'b0;
    done_d   = done_q;
    cnt_d    = cnt_q;
    if (do_abort) begin
      state_d  = ST_IDLE;
      clk_en_d = 1'b0;
      done_d   = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_d[i] = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_LOAD: begin
          if (ld_hs) begin
            cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            state_d   = ST_LOAD;
          end
          if (do_start) begin
            state_d  = ST_RUN;
            clk_en_d = 1'b1;
            settle_d = 1'b1;
          end
        end
        ST_RUN: begin
          start_d = settle_q && !done_i;
          if (done_i) begin
            state_d  = ST_DONE;
            clk_en_d = 1'b0;
            done_d   = 1'b1;
          end
        end
        ST_DONE: begin
          if (do_irqclr) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) cnt_d[i] = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign clk_en_o    = clk_en_q;
  assign start_o     = start_q;
  assign irq_o       = done_q;
  assign res_ready_o = HRESETn && !res_full;

  acc_res_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (32)
  ) u_res_fifo (
    .clk       (HCLK),
    .rst_n     (HRESETn),
    .push      (res_valid_i && res_ready_o),
    .push_data (res_data_i),
    .pop       (do_pop),
    .flush     (do_abort),
    .head      (res_head),
    .count     (res_count),
    .full      (res_full),
    .empty     (res_empty)
  );

endmodule

// File: tb/tb_acc_apb_frontend.sv
// Scoreboard bench for acc_apb_frontend: APB responses and operand handshakes
// are checked by monitors against queues filled by the stimulus thread.
module tb_acc_apb_frontend;

  localparam logic [11:0] A_CTRL   = 12'h000;
  localparam logic [11:0] A_STATUS = 12'h004;
  localparam logic [11:0] A_IRQCLR = 12'h008;
  localparam logic [11:0] A_RESULT = 12'h800;

  typedef struct packed {
    logic [11:0] addr;
    logic        err;
    logic        chk;
    logic [31:0] data;
  } apb_exp_t;

  typedef struct packed {
    logic        ch;
    logic [31:0] data;
  } ld_exp_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        clk_en_o, start_o, done_i, irq_o;
  logic        ld_valid_o, ld_ready_i;
  logic [0:0]  ld_ch_o;
  logic [31:0] ld_data_o;
  logic        res_valid_i, res_ready_o;
  logic [31:0] res_data_i;

  apb_exp_t apb_q[$];
  ld_exp_t  ld_q[$];
  apb_exp_t mon_apb;
  ld_exp_t  mon_ld;
  int       n_pass = 0;
  int       n_total = 0;

  acc_apb_frontend_if #(.ADDR_W(12)) apb ();

  acc_apb_frontend #(
    .APB_ADDR_WIDTH (12),
    .NUM_CH         (2),
    .WORDS_PER_CH   (16),
    .RES_DEPTH      (16)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .apb         (apb),
    .clk_en_o    (clk_en_o),
    .start_o     (start_o),
    .done_i      (done_i),
    .ld_valid_o  (ld_valid_o),
    .ld_ch_o     (ld_ch_o),
    .ld_data_o   (ld_data_o),
    .ld_ready_i  (ld_ready_i),
    .res_valid_i (res_valid_i),
    .res_data_i  (res_data_i),
    .res_ready_o (res_ready_o),
    .irq_o       (irq_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Every completed APB transfer must match the oldest queued expectation.
  always @(negedge HCLK) begin
    if (apb.PSEL && apb.PENABLE && apb.PREADY) begin
      if (apb_q.size() == 0) begin
        n_total++;
        $display("FAIL apb unexpected completion at %h", apb.PADDR);
      end else begin
        mon_apb = apb_q.pop_front();
        check($sformatf("apb %h pslverr", mon_apb.addr), 32'(apb.PSLVERR), 32'(mon_apb.err));
        if (mon_apb.chk) check($sformatf("apb %h prdata", mon_apb.addr), apb.PRDATA, mon_apb.data);
      end
    end
  end

  always @(negedge HCLK) begin
    if (ld_valid_o && ld_ready_i) begin
      if (ld_q.size() == 0) begin
        n_total++;
        $display("FAIL ld unexpected handshake ch %0d data %h", ld_ch_o, ld_data_o);
      end else begin
        mon_ld = ld_q.pop_front();
        check("ld ch", 32'(ld_ch_o), 32'(mon_ld.ch));
        check("ld data", ld_data_o, mon_ld.data);
      end
    end
  end

  task automatic xfer(input logic [11:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic exp_err, input logic [31:0] exp_rdata,
                      input int hold, input logic pulse_done, output int waits);
    apb_exp_t e;
    logic got;
    e.addr = addr;
    e.err  = exp_err;
    e.chk  = !wr && (!exp_err || addr == A_RESULT);
    e.data = exp_rdata;
    apb_q.push_back(e);
    waits = 0;
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    apb.PADDR = addr; apb.PWRITE = wr; apb.PWDATA = wdata;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    if (hold > 0) begin
      ld_ready_i = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge HCLK);
        if (!apb.PREADY) waits++;
        @(posedge HCLK); #1;
      end
      ld_ready_i = 1'b1;
    end
    if (pulse_done) done_i = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge HCLK);
      if (apb.PREADY) got = 1'b1;
      else waits++;
    end
    if (!got) begin
      n_total++;
      $display("FAIL apb %h timeout: got no PREADY, expected completion", addr);
      void'(apb_q.pop_back());
    end
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; done_i = 1'b0;
  endtask

  task automatic wr_ok(input logic [11:0] a, input logic [31:0] d);
    int w; xfer(a, 1'b1, d, 1'b0, 32'h0, 0, 1'b0, w);
  endtask
  task automatic wr_err(input logic [11:0] a, input logic [31:0] d);
    int w; xfer(a, 1'b1, d, 1'b1, 32'h0, 0, 1'b0, w);
  endtask
  task automatic rd(input logic [11:0] a, input logic [31:0] exp);
    int w; xfer(a, 1'b0, 32'h0, 1'b0, exp, 0, 1'b0, w);
  endtask
  task automatic rd_err(input logic [11:0] a);
    int w; xfer(a, 1'b0, 32'h0, 1'b1, 32'h0, 0, 1'b0, w);
  endtask

  task automatic op_wr(input logic ch, input int idx, input logic [31:0] d, input int hold, output int waits);
    ld_exp_t le;
    logic [11:0] a;
    le.ch = ch; le.data = d;
    ld_q.push_back(le);
    a = (ch ? 12'h200 : 12'h100) + {4'd0, 4'(idx), 4'd0};
    xfer(a, 1'b1, d, 1'b0, 32'h0, hold, 1'b0, waits);
  endtask

  initial begin
    int w;
    HRESETn = 1'b0; done_i = 1'b0; ld_ready_i = 1'b1;
    res_valid_i = 1'b0; res_data_i = '0;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PADDR = '0; apb.PWRITE = 1'b0; apb.PWDATA = '0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    check("rst pready", 32'(apb.PREADY), 0);
    check("rst pslverr", 32'(apb.PSLVERR), 0);
    check("rst clk_en", 32'(clk_en_o), 0);
    check("rst start", 32'(start_o), 0);
    check("rst irq", 32'(irq_o), 0);
    check("rst ld_valid", 32'(ld_valid_o), 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    rd(A_STATUS, 32'h0000_0000);
    rd_err(A_CTRL);
    wr_err(A_STATUS, 32'h0);
    wr_err(12'h00C, 32'h0);
    rd_err(12'h100);
    wr_err(A_CTRL, 32'd1);
    wr_err(A_CTRL, 32'd5);
    rd_err(A_RESULT);

    for (int k = 0; k < 16; k++) op_wr(1'b0, k, 32'hA000_0000 + 32'(k), 0, w);
    for (int k = 0; k < 15; k++) begin
      op_wr(1'b1, k, 32'hB000_0000 + 32'(k), (k == 7) ? 3 : 0, w);
      if (k == 7) check("stall pready low cycles", 32'(w), 3);
    end
    rd(A_STATUS, 32'h0001_0001);

    wr_err(A_CTRL, 32'd1);
    @(negedge HCLK);
    check("bad start clk_en", 32'(clk_en_o), 0);
    rd(A_STATUS, 32'h0001_0001);

    op_wr(1'b1, 15, 32'hB000_000F, 0, w);
    wr_err(12'h2FC, 32'hDEAD_BEEF);
    rd(A_STATUS, 32'h0003_0001);

    wr_ok(A_CTRL, 32'd1);
    @(negedge HCLK);
    check("T+1 clk_en", 32'(clk_en_o), 1);
    check("T+1 start", 32'(start_o), 0);
    @(negedge HCLK);
    check("T+2 start", 32'(start_o), 1);
    @(negedge HCLK);
    check("T+3 start", 32'(start_o), 0);
    check("T+3 clk_en", 32'(clk_en_o), 1);
    rd(A_STATUS, 32'h0003_0002);

    for (int k = 0; k < 16; k++) begin
      res_valid_i = 1'b1; res_data_i = 32'hC000_0000 + 32'(k);
      @(negedge HCLK);
      check("res_ready filling", 32'(res_ready_o), 1);
      @(posedge HCLK); #1;
    end
    res_data_i = 32'hC000_0010;
    @(negedge HCLK);
    check("res_ready full", 32'(res_ready_o), 0);
    rd(A_RESULT, 32'hC000_0000);
    @(negedge HCLK);
    check("res_ready after pop", 32'(res_ready_o), 1);
    @(posedge HCLK); #1;
    res_valid_i = 1'b0;
    rd(A_STATUS, 32'h0003_1002);

    @(posedge HCLK); #1;
    done_i = 1'b1;
    @(negedge HCLK);
    check("irq before done", 32'(irq_o), 0);
    @(posedge HCLK); #1;
    done_i = 1'b0;
    @(negedge HCLK);
    check("irq after done", 32'(irq_o), 1);
    check("clk_en after done", 32'(clk_en_o), 0);
    rd(A_STATUS, 32'h0003_1007);
    rd(A_RESULT, 32'hC000_0001);
    wr_ok(A_IRQCLR, 32'h0);
    @(negedge HCLK);
    check("irq after irqclr", 32'(irq_o), 0);
    rd(A_STATUS, 32'h0000_0F00);
    for (int k = 2; k <= 16; k++) rd(A_RESULT, 32'hC000_0000 + 32'(k));
    rd_err(A_RESULT);

    for (int k = 0; k < 16; k++) op_wr(1'b0, k, 32'h1000_0000 + 32'(k), 0, w);
    for (int k = 0; k < 16; k++) op_wr(1'b1, k, 32'h2000_0000 + 32'(k), 0, w);
    wr_ok(A_CTRL, 32'd1);
    res_valid_i = 1'b1; res_data_i = 32'h5555_0000;
    @(posedge HCLK); #1;
    res_data_i = 32'h5555_0001;
    @(posedge HCLK); #1;
    res_valid_i = 1'b0;
    rd(A_STATUS, 32'h0003_0202);
    xfer(A_CTRL, 1'b1, 32'd2, 1'b0, 32'h0, 0, 1'b1, w);
    @(negedge HCLK);
    check("abort+done irq", 32'(irq_o), 0);
    check("abort clk_en", 32'(clk_en_o), 0);
    rd(A_STATUS, 32'h0000_0000);
    rd_err(A_RESULT);

    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PADDR = 12'h100; apb.PWRITE = 1'b1;
    apb.PWDATA = 32'hDEAD_0001; ld_ready_i = 1'b0;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    @(negedge HCLK);
    check("mid ld_valid", 32'(ld_valid_o), 1);
    check("mid pready", 32'(apb.PREADY), 0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst mid pready", 32'(apb.PREADY), 0);
    check("rst mid ld_valid", 32'(ld_valid_o), 0);
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; ld_ready_i = 1'b1;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(A_STATUS, 32'h0000_0000);

    repeat (2) @(posedge HCLK);
    check("apb queue drained", 32'(apb_q.size()), 0);
    check("ld queue drained", 32'(ld_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
